cordic_vec_ieee754: RTL and testbench

//  Inverse of the rotation-mode CORDIC: takes a Q15 (cos, sin) vector and returns its angle atan2(y,x),
//  in radians, as an IEEE754 single. Iterative vectoring-mode CORDIC, one micro-rotation per clock.

---
 rtl/cordic_pkg.sv | 47 ++++
 rtl/cordic_fix2float.sv | 30 +++
 rtl/cordic_vec_ieee754.sv | 161 ++++++++++++++++
 tb/tb_cordic_vec_ieee754.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/cordic_pkg.sv
// Shared CORDIC definitions: arctangent table (Q3.16), pi, FSM state encoding.
// Used by both the rotation-mode and vectoring-mode cores so they share one table.
package cordic_pkg;

  localparam int unsigned ITER_MAX = 19;
  localparam int unsigned TAB_FRAC = 16;
  localparam int          PI_FIX   = 205887;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PREP,
    ST_ITER,
    ST_NORM,
    ST_DONE
  } cordic_state_e;

  // atan(2^-i) in Q3.16, rounded to nearest
  function automatic int atan_q16(input logic [4:0] idx);
    case (idx)
      5'd0:    return 51472;
      5'd1:    return 30386;
      5'd2:    return 16055;
      5'd3:    return 8150;
      5'd4:    return 4091;
      5'd5:    return 2047;
      5'd6:    return 1024;
      5'd7:    return 512;
      5'd8:    return 256;
      5'd9:    return 128;
      5'd10:   return 64;
      5'd11:   return 32;
      5'd12:   return 16;
      5'd13:   return 8;
      5'd14:   return 4;
      5'd15:   return 2;
      5'd16:   return 1;
      default: return 0;
    endcase
  endfunction

  // Rescale a Q.16 constant to another fractional width
  function automatic int scale_q16(input int v, input int unsigned frac);
    if (frac >= TAB_FRAC) return v <<< (frac - TAB_FRAC);
    return v >>> (TAB_FRAC - frac);
  endfunction

endpackage

// File: rtl/cordic_fix2float.sv
// Signed fixed-point (FRAC fractional bits) to IEEE754 single, truncating.
// Combinational; zero maps to +0. Requires FIX_W <= 24 so no mantissa bits are lost.
module cordic_fix2float
  import cordic_pkg::*;
#(
  parameter int unsigned FIX_W = 20,
  parameter int unsigned FRAC  = 16
) (
  input  logic signed [FIX_W-1:0] fix_i,
  output logic        [31:0]      float_o
);

  logic [FIX_W-1:0] mag;
  logic [4:0]       lead;
  logic [22:0]      mant;
  logic [7:0]       expo;

  always_comb begin
    mag  = fix_i[FIX_W-1] ? FIX_W'(-fix_i) : FIX_W'(fix_i);
    lead = '0;
    for (int unsigned b = 0; b < FIX_W; b++) begin
      if (mag[b]) lead = 5'(b);
    end
    // drop the hidden one and left-justify the remaining bits
    mant    = 23'({mag, 23'd0} >> lead);
    expo    = 8'(int'(lead) + 127 - int'(FRAC));
    float_o = (mag == '0) ? 32'd0 : {fix_i[FIX_W-1], expo, mant};
  end

endmodule

// File: rtl/cordic_vec_ieee754.sv
// Iterative vectoring-mode CORDIC: Q15 (x,y) -> atan2(y,x) in radians as IEEE754 single.
// Optional gain-compensated magnitude output when CORDIC_MAG_EN is defined.
module cordic_vec_ieee754
  import cordic_pkg::*;
#(
  parameter int unsigned ITERATIONS = 16,
  parameter int unsigned ANGLE_FRAC = 16,
  parameter int unsigned DATA_W     = 20
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        valid_in,
  input  logic [15:0] x_q15,
  input  logic [15:0] y_q15,
  output logic [31:0] angle_ieee754,
  output logic        valid,
  output logic        busy,
  output logic [1:0]  quad_out
`ifdef CORDIC_MAG_EN
  ,
  output logic [15:0] mag_q15
`endif
);

  localparam int unsigned Z_W = ANGLE_FRAC + 4;
  localparam logic [4:0] ITER_LAST = 5'(ITERATIONS - 1);
  localparam logic signed [Z_W-1:0] PI_Z = Z_W'(scale_q16(PI_FIX, ANGLE_FRAC));

  cordic_state_e             state_q;
  logic [4:0]                iter_q;
  logic signed [DATA_W-1:0]  x_q, y_q;
  logic signed [Z_W-1:0]     z_q;
  logic                      zero_q;
  logic [31:0]               angle_q;
  logic [1:0]                quad_q;
  logic                      valid_q, busy_q;

  logic signed [DATA_W-1:0]  x_sh, y_sh, x_it_d, y_it_d, x_fold_d, y_fold_d;
  logic signed [Z_W-1:0]     atan_z, z_it_d, z_fold_d;
  logic [31:0]               float_d;

`ifdef CORDIC_MAG_EN
  logic [15:0]                mag_q, mag_d;
  logic signed [DATA_W+15:0]  mag_full;
`endif

  // Micro-rotation step and half-plane fold, both from the current registers
  always_comb begin
    x_sh   = x_q >>> iter_q;
    y_sh   = y_q >>> iter_q;
    atan_z = Z_W'(scale_q16(atan_q16(iter_q), ANGLE_FRAC));
    if (!y_q[DATA_W-1]) begin
      x_it_d = x_q + y_sh;
      y_it_d = y_q - x_sh;
      z_it_d = z_q + atan_z;
    end else begin
      x_it_d = x_q - y_sh;
      y_it_d = y_q + x_sh;
      z_it_d = z_q - atan_z;
    end
    x_fold_d = x_q;
    y_fold_d = y_q;
    z_fold_d = '0;
    if (x_q[DATA_W-1]) begin
      x_fold_d = -x_q;
      y_fold_d = -y_q;
      z_fold_d = y_q[DATA_W-1] ? -PI_Z : PI_Z;
    end
  end

`ifdef CORDIC_MAG_EN
  // Scale by K^-1 (0.60725 in Q15) and clamp to the Q15 positive range
  always_comb begin
    mag_full = ((DATA_W+16)'(x_q) * (DATA_W+16)'(16'sd19898)) >>> 15;
    if (mag_full > (DATA_W+16)'(32767))   mag_d = 16'h7FFF;
    else if (mag_full < 0)                mag_d = 16'h0000;
    else                                  mag_d = mag_full[15:0];
  end
`endif

  cordic_fix2float #(
    .FIX_W (Z_W),
    .FRAC  (ANGLE_FRAC)
  ) u_fix2float (
    .fix_i   (z_q),
    .float_o (float_d)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      iter_q  <= '0;
      x_q     <= '0;
      y_q     <= '0;
      z_q     <= '0;
      zero_q  <= 1'b0;
      angle_q <= '0;
      quad_q  <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
`ifdef CORDIC_MAG_EN
      mag_q   <= '0;
`endif
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (valid_in) begin
            x_q     <= DATA_W'(signed'(x_q15));
            y_q     <= DATA_W'(signed'(y_q15));
            z_q     <= '0;
            iter_q  <= '0;
            zero_q  <= (x_q15 == 16'd0) && (y_q15 == 16'd0);
            quad_q  <= {y_q15[15], x_q15[15]};
            busy_q  <= 1'b1;
            state_q <= ST_PREP;
          end
        end
        ST_PREP: begin
          x_q     <= x_fold_d;
          y_q     <= y_fold_d;
          z_q     <= z_fold_d;
          state_q <= ST_ITER;
        end
        ST_ITER: begin
          x_q    <= x_it_d;
          y_q    <= y_it_d;
          z_q    <= z_it_d;
          iter_q <= iter_q + 5'd1;
          if (iter_q == ITER_LAST) state_q <= ST_NORM;
        end
        ST_NORM: begin
          angle_q <= zero_q ? 32'd0 : float_d;
`ifdef CORDIC_MAG_EN
          mag_q   <= mag_d;
`endif
          state_q <= ST_DONE;
        end
        ST_DONE: begin
          // first DONE cycle presents the registered result, second retires it
          if (!valid_q) begin
            valid_q <= 1'b1;
          end else begin
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign angle_ieee754 = angle_q;
  assign valid         = valid_q;
  assign busy          = busy_q;
  assign quad_out      = quad_q;
`ifdef CORDIC_MAG_EN
  assign mag_q15       = mag_q;
`endif

endmodule

// File: tb/tb_cordic_vec_ieee754.sv
// Self-checking bench for cordic_vec_ieee754: directed corner vectors, random vectors
// against a real-valued atan2 model, busy/valid timing, ignored re-request, mid-run reset.
module tb_cordic_vec_ieee754;

  localparam real PI  = 3.14159265358979;
  localparam real TOL = 4.0e-4;

  logic        clk;
  logic        rst;
  logic        valid_in;
  logic [15:0] x_q15, y_q15;
  logic [31:0] angle_ieee754;
  logic        valid, busy;
  logic [1:0]  quad_out;
`ifdef CORDIC_MAG_EN
  logic [15:0] mag_q15;
`endif

  int n_checks = 0;
  int n_errors = 0;
  int n_valid  = 0;

  cordic_vec_ieee754 dut (
    .clk           (clk),
    .rst           (rst),
    .valid_in      (valid_in),
    .x_q15         (x_q15),
    .y_q15         (y_q15),
    .angle_ieee754 (angle_ieee754),
    .valid         (valid),
    .busy          (busy),
    .quad_out      (quad_out)
`ifdef CORDIC_MAG_EN
    ,
    .mag_q15       (mag_q15)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    #1;
    if (valid) n_valid++;
  end

  task automatic check(input string tag, input real got, input real want, input real tol);
    n_checks++;
    if ((got - want > tol) || (want - got > tol)) begin
      n_errors++;
      $display("FAIL %s got %0.6f want %0.6f (tol %0.6f)", tag, got, want, tol);
    end
  endtask

  function automatic real f32_to_real(input logic [31:0] b);
    real m;
    int  e;
    if (b[30:0] == 31'd0) return 0.0;
    e = int'(b[30:23]) - 127;
    m = 1.0 + real'(b[22:0]) / 8388608.0;
    for (int k = 0; k < e; k++) m = m * 2.0;
    for (int k = 0; k > e; k--) m = m / 2.0;
    return b[31] ? -m : m;
  endfunction

  function automatic real ref_angle(input logic [15:0] x, input logic [15:0] y);
    real rx, ry;
    if (x == 16'd0 && y == 16'd0) return 0.0;
    rx = real'($signed(x));
    ry = real'($signed(y));
    return $atan2(ry, rx);
  endfunction

  task automatic send(input logic [15:0] x, input logic [15:0] y);
    @(negedge clk);
    valid_in = 1'b1;
    x_q15    = x;
    y_q15    = y;
    @(posedge clk);
    #1 valid_in = 1'b0;
  endtask

  // lat = edges from the capture edge to the first valid; 0 on timeout
  task automatic wait_result(output logic [31:0] ang, output logic [1:0] q, output int lat);
    lat = 0;
    for (int k = 1; k <= 60; k++) begin
      @(posedge clk);
      #1;
      if (valid) begin
        lat = k;
        break;
      end
    end
    ang = angle_ieee754;
    q   = quad_out;
  endtask

  task automatic run_vec(input string tag, input logic [15:0] x, input logic [15:0] y,
                         output logic [31:0] ang);
    logic [1:0] q;
    int         lat;
    real        got, want;
    send(x, y);
    check({tag, "_busy"}, real'(busy), 1.0, 0.0);
    wait_result(ang, q, lat);
    check({tag, "_lat"}, real'(lat), 19.0, 0.0);
    check({tag, "_quad"}, real'(q), real'({y[15], x[15]}), 0.0);
    got  = f32_to_real(ang);
    want = ref_angle(x, y);
    if (got - want > PI) want += 2.0 * PI;
    else if (want - got > PI) want -= 2.0 * PI;
    check({tag, "_ang"}, got, want, TOL);
    @(posedge clk);
    #1;
    check({tag, "_vend"}, real'(valid), 0.0, 0.0);
    check({tag, "_bend"}, real'(busy), 0.0, 0.0);
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] ang;
    logic [1:0]  q;
    int          lat, nv0;
    real         got;

    rst = 1'b1; valid_in = 1'b0; x_q15 = '0; y_q15 = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_angle", real'(angle_ieee754), 0.0, 0.0);
    check("rst_valid", real'(valid), 0.0, 0.0);
    check("rst_busy",  real'(busy), 0.0, 0.0);
    check("rst_quad",  real'(quad_out), 0.0, 0.0);
    rst = 1'b0;
    repeat (2) @(posedge clk);

    // directed corner vectors
    run_vec("x_pos",  16'h7FFF, 16'h0000, ang);
    run_vec("diag",   16'h5A82, 16'h5A82, ang);
    run_vec("y_pos",  16'h0000, 16'h7FFF, ang);
    run_vec("y_neg",  16'h0000, 16'h8001, ang);
    run_vec("x_min",  16'h8000, 16'h0000, ang);
    check("x_min_sign", real'(ang[31]), 0.0, 0.0);
    got = f32_to_real(ang);
    check("x_min_pi", got, PI, TOL);
    run_vec("neg_pi", 16'h8000, 16'hFFFF, ang);
    got = f32_to_real(ang);
    check("neg_pi_val", got, -PI, TOL);
    run_vec("zero",   16'h0000, 16'h0000, ang);
    check("zero_bits", real'(ang), 0.0, 0.0);

    // random vectors with magnitude >= 0.5
    for (int n = 0; n < 40; n++) begin
      logic [15:0] rx, ry;
      longint      m2;
      do begin
        rx = 16'($urandom);
        ry = 16'($urandom);
        m2 = longint'($signed(rx)) * longint'($signed(rx)) +
             longint'($signed(ry)) * longint'($signed(ry));
      end while (m2 < 64'sd268435456);
      run_vec("rand", rx, ry, ang);
    end

    // second request while busy must be ignored
    nv0 = n_valid;
    send(16'h5A82, 16'h5A82);
    repeat (4) @(posedge clk);
    @(negedge clk);
    valid_in = 1'b1; x_q15 = 16'h7FFF; y_q15 = 16'h0000;
    @(posedge clk);
    #1 valid_in = 1'b0;
    wait_result(ang, q, lat);
    check("repulse_lat", real'(lat + 5), 19.0, 0.0);
    check("repulse_ang", f32_to_real(ang), PI / 4.0, TOL);
    repeat (30) @(posedge clk);
    #1;
    check("repulse_count", real'(n_valid - nv0), 1.0, 0.0);

    // reset in the middle of a run aborts it
    send(16'h8000, 16'h8001);
    repeat (8) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1;
    check("abort_angle", real'(angle_ieee754), 0.0, 0.0);
    check("abort_busy",  real'(busy), 0.0, 0.0);
    check("abort_quad",  real'(quad_out), 0.0, 0.0);
    check("abort_valid", real'(valid), 0.0, 0.0);
    rst = 1'b0;
    nv0 = n_valid;
    repeat (30) @(posedge clk);
    #1;
    check("abort_novalid", real'(n_valid - nv0), 0.0, 0.0);
    run_vec("post_rst", 16'hC000, 16'h4000, ang);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
